systolic_feeder: RTL and testbench



---
 rtl/systolic_feeder.sv | 130 +++++++++++++
 tb/tb_systolic_feeder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - captures A/B tiles and emits skewed per-lane operand streams to a systolic array
module systolic_feeder #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int K  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N*K*DW-1:0] a_mat_flat,
   input  logic [K*N*DW-1:0] b_mat_flat,
   output logic              ready,
   output logic              busy,
   output logic              arr_clr,
   output logic [N*DW-1:0]   a_left_flat,
   output logic [N-1:0]      a_v_row_flat,
   output logic [N*DW-1:0]   b_top_flat,
   output logic [N-1:0]      b_v_col_flat,
   output logic              feed_done
);

   localparam int CW = $clog2(K + N);
   localparam logic [CW-1:0] T_LAST = CW'(K + N - 2);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CLR  = 2'd1;
   localparam logic [1:0] S_FEED = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]         state;
   logic [CW-1:0]      t;
   logic [CW-1:0]      beat_t;
   logic [N*K*DW-1:0]  a_cap;
   logic [K*N*DW-1:0]  b_cap;
   logic [N*DW-1:0]    a_beat;
   logic [N*DW-1:0]    b_beat;
   logic [N-1:0]       va_beat;
   logic [N-1:0]       vb_beat;
   logic               accept;

   assign accept = start && ready;

   // Index of the beat that will be registered at the next edge (0 when leaving CLR)
   always_comb begin
      beat_t = '0;
      if (state == S_FEED) beat_t = t + CW'(1);
   end

   // Skewed lane contents for beat_t: row i carries A[i][beat_t-i], column j carries B[beat_t-j][j]
   always_comb begin
      a_beat  = '0;
      b_beat  = '0;
      va_beat = '0;
      vb_beat = '0;
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < K; k++) begin
            if (int'(beat_t) == i + k) begin
               va_beat[i]          = 1'b1;
               a_beat[i*DW +: DW]  = a_cap[(i*K+k)*DW +: DW];
               vb_beat[i]          = 1'b1;
               b_beat[i*DW +: DW]  = b_cap[(k*N+i)*DW +: DW];
            end
         end
      end
   end

   // Tile sequencer: IDLE -> CLR -> FEED (K+N-1 beats) -> DONE, with back-to-back accept from DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         t            <= '0;
         a_cap        <= '0;
         b_cap        <= '0;
         ready        <= 1'b1;
         busy         <= 1'b0;
         arr_clr      <= 1'b0;
         feed_done    <= 1'b0;
         a_left_flat  <= '0;
         b_top_flat   <= '0;
         a_v_row_flat <= '0;
         b_v_col_flat <= '0;
      end else begin
         arr_clr   <= 1'b0;
         feed_done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  a_cap   <= a_mat_flat;
                  b_cap   <= b_mat_flat;
                  state   <= S_CLR;
                  arr_clr <= 1'b1;
                  busy    <= 1'b1;
                  ready   <= 1'b0;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_CLR: begin
               state        <= S_FEED;
               t            <= '0;
               a_left_flat  <= a_beat;
               b_top_flat   <= b_beat;
               a_v_row_flat <= va_beat;
               b_v_col_flat <= vb_beat;
            end
            S_FEED: begin
               if (t == T_LAST) begin
                  state        <= S_DONE;
                  t            <= '0;
                  feed_done    <= 1'b1;
                  busy         <= 1'b0;
                  ready        <= 1'b1;
                  a_left_flat  <= '0;
                  b_top_flat   <= '0;
                  a_v_row_flat <= '0;
                  b_v_col_flat <= '0;
               end else begin
                  t            <= beat_t;
                  a_left_flat  <= a_beat;
                  b_top_flat   <= b_beat;
                  a_v_row_flat <= va_beat;
                  b_v_col_flat <= vb_beat;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - scoreboard bench for systolic_feeder with randomized tiles and a spec-level model
module tb_systolic_feeder;

   localparam int N  = 4;
   localparam int K  = 4;
   localparam int DW = 8;
   localparam int NB = K + N - 1;
   localparam int VW = 4 + 2*N + 2*N*DW;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [N*K*DW-1:0] a_mat_flat;
   logic [K*N*DW-1:0] b_mat_flat;
   logic              ready;
   logic              busy;
   logic              arr_clr;
   logic [N*DW-1:0]   a_left_flat;
   logic [N-1:0]      a_v_row_flat;
   logic [N*DW-1:0]   b_top_flat;
   logic [N-1:0]      b_v_col_flat;
   logic              feed_done;

   systolic_feeder #(.N(N), .DW(DW), .K(K)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .a_mat_flat   (a_mat_flat),
      .b_mat_flat   (b_mat_flat),
      .ready        (ready),
      .busy         (busy),
      .arr_clr      (arr_clr),
      .a_left_flat  (a_left_flat),
      .a_v_row_flat (a_v_row_flat),
      .b_top_flat   (b_top_flat),
      .b_v_col_flat (b_v_col_flat),
      .feed_done    (feed_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              cyc;
      logic [VW-1:0]   v;
   } frame_t;

   frame_t q[$];
   int     cyc = 0;
   int     next_accept = 0;
   int     n_checks = 0;
   int     n_fail = 0;
   bit     mon_en = 1'b0;
   int     am[N][K];
   int     bm[K][N];

   function automatic logic [VW-1:0] pack(logic clr, logic done, logic rdy, logic bsy,
                                          logic [N-1:0] va, logic [N-1:0] vb,
                                          logic [N*DW-1:0] a, logic [N*DW-1:0] b);
      return {clr, done, rdy, bsy, va, vb, a, b};
   endfunction

   task automatic set_mats();
      for (int i = 0; i < N; i++)
         for (int k = 0; k < K; k++) begin
            a_mat_flat[(i*K+k)*DW +: DW] = DW'(am[i][k]);
            b_mat_flat[(k*N+i)*DW +: DW] = DW'(bm[k][i]);
         end
   endtask

   task automatic scramble();
      for (int i = 0; i < N; i++)
         for (int k = 0; k < K; k++) begin
            am[i][k] = int'($urandom_range(0, 255)) - 128;
            bm[k][i] = int'($urandom_range(0, 255)) - 128;
         end
      set_mats();
   endtask

   // Expected output timeline for a tile accepted in cycle c0, built from the skew rule
   task automatic push_tile(int c0);
      frame_t          f;
      logic [N-1:0]    va, vb;
      logic [N*DW-1:0] al, bl;
      f.cyc = c0 + 1;
      f.v   = pack(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, '0, '0);
      q.push_back(f);
      for (int t = 0; t < NB; t++) begin
         va = '0; vb = '0; al = '0; bl = '0;
         for (int l = 0; l < N; l++) begin
            int kk;
            kk = t - l;
            if (kk >= 0 && kk < K) begin
               va[l] = 1'b1;
               al[l*DW +: DW] = DW'(am[l][kk]);
               vb[l] = 1'b1;
               bl[l*DW +: DW] = DW'(bm[kk][l]);
            end
         end
         f.cyc = c0 + 2 + t;
         f.v   = pack(1'b0, 1'b0, 1'b0, 1'b1, va, vb, al, bl);
         q.push_back(f);
      end
      f.cyc = c0 + NB + 2;
      f.v   = pack(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, '0, '0);
      q.push_back(f);
      next_accept = c0 + NB + 2;
   endtask

   task automatic step(logic s, logic r);
      start = s;
      rst   = r;
      if (r) begin
         while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
         next_accept = cyc + 1;
      end else if (s && cyc >= next_accept) begin
         push_tile(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Monitor: compares every cycle's outputs against the scheduled frame, or the idle state
   always @(negedge clk) begin : mon
      logic [VW-1:0] act, exp;
      string         nm;
      if (mon_en) begin
         while (q.size() > 0 && q[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL stale_frame cycle %0d: expected frame for cycle %0d never checked", cyc, q[0].cyc);
            void'(q.pop_front());
         end
         act = pack(arr_clr, feed_done, ready, busy, a_v_row_flat, b_v_col_flat, a_left_flat, b_top_flat);
         if (q.size() > 0 && q[0].cyc == cyc) begin
            exp = q[0].v;
            void'(q.pop_front());
            nm = "frame";
         end else begin
            exp = pack(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
            nm = "idle";
         end
         n_checks++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h (clr,done,rdy,busy,va,vb,a,b)", nm, cyc, act, exp);
         end
      end
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      for (int i = 0; i < N; i++)
         for (int k = 0; k < K; k++) begin
            am[i][k] = 0;
            bm[k][i] = 0;
         end
      set_mats();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      next_accept = 0;
      mon_en = 1'b1;

      repeat (5) step(1'b0, 1'b0);

      // Ascending A with identity B; inputs scrambled after acceptance must not leak in
      for (int i = 0; i < N; i++)
         for (int k = 0; k < K; k++) begin
            am[i][k] = i*4 + k + 1;
            bm[k][i] = (k == i) ? 1 : 0;
         end
      set_mats();
      step(1'b1, 1'b0);
      for (int c = 0; c < 12; c++) begin
         scramble();
         step(1'b0, 1'b0);
      end

      // Extreme signed operands
      for (int i = 0; i < N; i++)
         for (int k = 0; k < K; k++) begin
            am[i][k] = -128;
            bm[k][i] = 127;
         end
      set_mats();
      step(1'b1, 1'b0);
      repeat (12) step(1'b0, 1'b0);

      // start held high: back-to-back tiles, mid-tile starts ignored
      for (int c = 0; c < 2*(NB+2) + 1; c++) begin
         scramble();
         step(1'b1, 1'b0);
      end
      repeat (12) step(1'b0, 1'b0);

      // Reset in cycle 4 of a tile
      scramble();
      step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      repeat (6) step(1'b0, 1'b0);

      // Random traffic with occasional resets
      for (int c = 0; c < 400; c++) begin
         logic s, r;
         scramble();
         r = ($urandom_range(0, 59) == 0);
         s = ($urandom_range(0, 2) == 0) && !r;
         step(s, r);
      end
      repeat (14) step(1'b0, 1'b0);

      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected frames left, required 0", q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
